// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the register-file write path.
package reg_file_pkg;

    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned REG_WIDTH  = 32;
    localparam int unsigned NUM_REQ    = 4;

    // One register-file write: target register and the data to put there.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]  val;
    } wr_req_t;

    // Round-robin increment that wraps at n-1, so indices >= n are never produced.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid at or after ptr, wrapping at N.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned GW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [GW-1:0] grant_idx
);

    // One extra bit so ptr + offset cannot overflow before the explicit wrap.
    localparam int unsigned KW = GW + 1;

    logic [KW-1:0] k;
    logic          found;

    // Scan ptr, ptr+1, ... modulo N and keep the first asserted request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = {1'b0, ptr} + KW'(i);
            if (k >= KW'(N)) begin
                k = k - KW'(N);
            end
            if (!found && valid[k[GW-1:0]]) begin
                found              = 1'b1;
                grant[k[GW-1:0]]   = 1'b1;
                grant_idx          = k[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin sharing of the single register-file write port among NUM_REQ requesters.
// NUM_REQ must be at least 2.
module reg_file_wr_arbiter #(
    parameter int unsigned ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter int unsigned REG_WIDTH  = reg_file_pkg::REG_WIDTH,
    parameter int unsigned NUM_REQ    = reg_file_pkg::NUM_REQ,
    localparam int unsigned GID_W     = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  i_req_val,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [ADDR_WIDTH-1:0]         o_reg_addr_w,
    output logic [REG_WIDTH-1:0]          o_reg_val_w,
    output logic                          o_write_en,
    output logic [GID_W-1:0]              o_grant_id
);

    import reg_file_pkg::*;

    logic [NUM_REQ-1:0]    grant;
    logic [GID_W-1:0]      grant_idx;
    logic [GID_W-1:0]      rr_ptr;
    logic [GID_W-1:0]      rr_next;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [REG_WIDTH-1:0]  sel_val;

    rr_arbiter #(
        .N  (NUM_REQ),
        .GW (GID_W)
    ) u_arb (
        .valid     (i_req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is only offered to valid requesters, and never while reset is held.
    assign o_req_ready = i_rst_n ? grant : '0;
    assign accept      = |grant;
    assign rr_next     = GID_W'(rr_wrap_inc(32'(grant_idx), NUM_REQ));

    // Route the granted requester's address and data to the output stage.
    always_comb begin
        sel_addr = '0;
        sel_val  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_val  = i_req_val[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Output stage and round-robin pointer; write enable pulses once per accepted request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_write_en   <= 1'b0;
            o_reg_addr_w <= '0;
            o_reg_val_w  <= '0;
            o_grant_id   <= '0;
            rr_ptr       <= '0;
        end else if (accept) begin
            o_write_en   <= 1'b1;
            o_reg_addr_w <= sel_addr;
            o_reg_val_w  <= sel_val;
            o_grant_id   <= grant_idx;
            rr_ptr       <= rr_next;
        end else begin
            o_write_en   <= 1'b0;
        end
    end

    // At most one requester is granted at a time.
    a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_req_ready));

    // A write on the port must come from a handshake on the previous edge.
    a_we_has_source: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_write_en |-> $past(|(i_req_valid & o_req_ready)));

    // Requesters hold valid, addr and val until they are granted.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_hold
        a_req_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (i_req_valid[gi] && !o_req_ready[gi]) |=>
            (i_req_valid[gi]
             && $stable(i_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH])
             && $stable(i_req_val[gi*REG_WIDTH +: REG_WIDTH])));
    end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter feeding a simple register file.
module tb_reg_file_wr_arbiter;
    import reg_file_pkg::*;

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned RW = REG_WIDTH;
    localparam int unsigned NR = NUM_REQ;
    localparam int unsigned GW = $clog2(NR);

    logic              i_clk;
    logic              i_rst_n;
    logic [NR-1:0]     i_req_valid;
    logic [NR*AW-1:0]  i_req_addr;
    logic [NR*RW-1:0]  i_req_val;
    logic [NR-1:0]     o_req_ready;
    logic [AW-1:0]     o_reg_addr_w;
    logic [RW-1:0]     o_reg_val_w;
    logic              o_write_en;
    logic [GW-1:0]     o_grant_id;

    wr_req_t           req_drv [NR];
    logic              rf_clr;
    logic              chk_en;
    logic [RW-1:0]     rf [1<<AW];
    int                n_wr;
    int                n_cmp;
    int                n_bad;

    reg_file_wr_arbiter dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_val    (i_req_val),
        .o_req_ready  (o_req_ready),
        .o_reg_addr_w (o_reg_addr_w),
        .o_reg_val_w  (o_reg_val_w),
        .o_write_en   (o_write_en),
        .o_grant_id   (o_grant_id)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            i_req_addr[i*AW +: AW] = req_drv[i].addr;
            i_req_val[i*RW +: RW]  = req_drv[i].val;
        end
    end

    // Register file behind the write port.
    always @(posedge i_clk) begin
        if (rf_clr) begin
            for (int r = 0; r < (1<<AW); r++) rf[r] <= '0;
            n_wr <= 0;
        end else if (o_write_en) begin
            rf[o_reg_addr_w] <= o_reg_val_w;
            n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int            m_ptr;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [RW-1:0] m_val;
    logic [GW-1:0] m_gid;
    logic [RW-1:0] exp_rf [1<<AW];
    int            m_writes;

    // Winner = valid requester at the smallest forward distance from the pointer.
    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        int n    = NR;
        int best = -1;
        int bd   = n;
        for (int k = 0; k < n; k++) begin
            if (v[k]) begin
                int d = (k - ptr + n) % n;
                if (d < bd) begin
                    bd   = d;
                    best = k;
                end
            end
        end
        return best;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        int g;
        if (rf_clr) begin
            for (int r = 0; r < (1<<AW); r++) exp_rf[r] = '0;
            m_writes = 0;
        end
        if (!i_rst_n) begin
            m_ptr = 0; m_we = 1'b0; m_addr = '0; m_val = '0; m_gid = '0;
        end else begin
            if (m_we && !rf_clr) begin
                exp_rf[m_addr] = m_val;
                m_writes++;
            end
            g = pick(i_req_valid, m_ptr);
            if (g >= 0) begin
                m_we   = 1'b1;
                m_addr = req_drv[g].addr;
                m_val  = req_drv[g].val;
                m_gid  = GW'(g);
                m_ptr  = (g + 1) % NR;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of every DUT output against the model.
    always @(negedge i_clk) begin
        if (chk_en) begin
            if (!i_rst_n) begin
                chk("rst_ready", 64'(o_req_ready), 64'(0));
                chk("rst_we", 64'(o_write_en), 64'(0));
            end else begin
                logic [NR-1:0] er;
                int g;
                er = '0;
                g  = pick(i_req_valid, m_ptr);
                if (g >= 0) er[g] = 1'b1;
                chk("cyc_ready", 64'(o_req_ready), 64'(er));
                chk("cyc_we", 64'(o_write_en), 64'(m_we));
                chk("cyc_addr", 64'(o_reg_addr_w), 64'(m_addr));
                chk("cyc_val", 64'(o_reg_val_w), 64'(m_val));
                chk("cyc_gid", 64'(o_grant_id), 64'(m_gid));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [RW-1:0] d);
        req_drv[i].addr = a;
        req_drv[i].val  = d;
        i_req_valid[i]  = v;
    endtask

    task automatic step(output logic [NR-1:0] hs);
        #1;
        hs = i_req_valid & o_req_ready;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clk); #1 i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk); #1 i_rst_n = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] hs;
        int rem [NR];
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        i_req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            req_drv[i].addr = '0; req_drv[i].val = '0;
        end
        i_rst_n = 1'b1; rf_clr = 1'b1;
        #1 i_rst_n = 1'b0;

        // Reset state, with a request present that must not be granted.
        set_req(1, 1'b1, 3'd4, 32'h1234);
        #1;
        chk("reset_ready", 64'(o_req_ready), 64'(0));
        chk("reset_we", 64'(o_write_en), 64'(0));
        chk("reset_addr", 64'(o_reg_addr_w), 64'(0));
        chk("reset_val", 64'(o_reg_val_w), 64'(0));
        chk("reset_gid", 64'(o_grant_id), 64'(0));
        set_req(1, 1'b0, 3'd0, 32'h0);
        repeat (2) @(posedge i_clk);
        #1 rf_clr = 1'b0;
        @(negedge i_clk); #1 i_rst_n = 1'b1;
        chk_en = 1'b1;

        // Single request from requester 1.
        #1 set_req(1, 1'b1, 3'd5, 32'hDEAD_BEEF);
        #1 chk("single_ready", 64'(o_req_ready), 64'(4'b0010));
        step(hs);
        set_req(1, 1'b0, 3'd5, 32'hDEAD_BEEF);
        chk("single_we", 64'(o_write_en), 64'(1));
        chk("single_gid", 64'(o_grant_id), 64'(1));
        chk("single_addr", 64'(o_reg_addr_w), 64'(5));
        step(hs);
        chk("single_rf5", 64'(rf[5]), 64'(32'hDEAD_BEEF));
        chk("single_we_off", 64'(o_write_en), 64'(0));

        // All four requesting twice each from pointer 0.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            rem[i] = 2;
            set_req(i, 1'b1, AW'(i), RW'(32'hA0 + i));
        end
        for (int c = 0; c < 8; c++) begin
            step(hs);
            chk("rr_we", 64'(o_write_en), 64'(1));
            chk("rr_order", 64'(o_grant_id), 64'(c % 4));
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) i_req_valid[i] = 1'b0;
                end
            end
        end
        chk("rr_all_done", 64'(i_req_valid), 64'(0));
        step(hs);
        chk("rr_we_off", 64'(o_write_en), 64'(0));

        // Collision on addr 2 with pointer moved to 3.
        set_req(2, 1'b1, 3'd4, 32'h22);
        step(hs);
        set_req(2, 1'b0, 3'd4, 32'h22);
        set_req(0, 1'b1, 3'd2, 32'h11);
        set_req(3, 1'b1, 3'd2, 32'h33);
        step(hs);
        chk("coll_first", 64'(hs), 64'(4'b1000));
        chk("coll_gid3", 64'(o_grant_id), 64'(3));
        set_req(3, 1'b0, 3'd2, 32'h33);
        step(hs);
        chk("coll_second", 64'(hs), 64'(4'b0001));
        set_req(0, 1'b0, 3'd2, 32'h11);
        step(hs);
        chk("coll_rf2", 64'(rf[2]), 64'(32'h11));

        // Wrap: pointer 3, only requester 0 -> pointer becomes 1.
        set_req(2, 1'b1, 3'd4, 32'h44);
        step(hs);
        set_req(2, 1'b0, 3'd4, 32'h44);
        set_req(0, 1'b1, 3'd1, 32'h55);
        step(hs);
        chk("wrap_grant0", 64'(hs), 64'(4'b0001));
        set_req(0, 1'b1, 3'd1, 32'h66);
        set_req(1, 1'b1, 3'd3, 32'h77);
        step(hs);
        chk("wrap_ptr1", 64'(hs), 64'(4'b0010));
        set_req(1, 1'b0, 3'd3, 32'h77);
        step(hs);
        chk("wrap_then0", 64'(hs), 64'(4'b0001));
        set_req(0, 1'b0, 3'd1, 32'h66);

        // Reset while a write to reg 7 is on the port.
        set_req(2, 1'b1, 3'd7, 32'hAA);
        step(hs);
        chk("rmid_hs", 64'(hs), 64'(4'b0100));
        set_req(2, 1'b0, 3'd7, 32'hAA);
        chk("rmid_we_on", 64'(o_write_en), 64'(1));
        chk("rmid_addr", 64'(o_reg_addr_w), 64'(7));
        #1 i_rst_n = 1'b0;
        #1 chk("rmid_we_drop", 64'(o_write_en), 64'(0));
        @(posedge i_clk);
        @(negedge i_clk); #1 i_rst_n = 1'b1;
        #1 chk("rmid_rf7", 64'(rf[7]), 64'(0));
        set_req(0, 1'b1, 3'd6, 32'hBB);
        set_req(3, 1'b1, 3'd6, 32'hCC);
        #1 chk("rmid_ptr0", 64'(o_req_ready), 64'(4'b0001));
        step(hs);
        set_req(0, 1'b0, 3'd6, 32'hBB);
        step(hs);
        chk("rmid_next3", 64'(hs), 64'(4'b1000));
        set_req(3, 1'b0, 3'd6, 32'hCC);
        step(hs);

        // Idle: nothing written, contents stay put.
        for (int c = 0; c < 5; c++) begin
            step(hs);
            chk("idle_we", 64'(o_write_en), 64'(0));
        end
        for (int r = 0; r < (1<<AW); r++) chk("idle_rf", 64'(rf[r]), 64'(exp_rf[r]));
        chk("lit_rf0", 64'(rf[0]), 64'(32'hA0));
        chk("lit_rf1", 64'(rf[1]), 64'(32'h66));
        chk("lit_rf3", 64'(rf[3]), 64'(32'h77));
        chk("lit_rf6", 64'(rf[6]), 64'(32'hCC));
        chk("write_count_model", 64'(n_wr), 64'(m_writes));
        chk("write_count_lit", 64'(n_wr), 64'(18));

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
